conv_ber_monitor: RTL and testbench

- Bit-error monitor downstream of the Viterbi decoder in the ConvCode chain.
- Keeps a history of the source bits that enter the convolutional encoder.
- Searches for the decoder's latency in source bits and locks onto it.
- Once locked, compares every decoded bit with the delayed source bit and reports per-bit error pulses, saturating running counts and per-window error totals for BER measurement under injected noise.

---
 rtl/conv_ber_monitor_if.sv | 29 ++
 rtl/conv_ber_monitor.sv | 167 ++++++++++++++++
 tb/tb_conv_ber_monitor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_ber_monitor_if.sv
// Bundle of source/decoded bit streams and BER monitor status for conv_ber_monitor.
// The slave modport belongs to the monitor; the master modport belongs to whoever feeds it.
interface conv_ber_monitor_if #(
    parameter int DLY_W = 6,
    parameter int CNT_W = 16
);
    logic             src_bit;
    logic             src_valid;
    logic             dec_bit;
    logic             dec_valid;
    logic             clear;
    logic             locked;
    logic [DLY_W-1:0] delay_est;
    logic             err_flag;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             win_done;
    logic [CNT_W-1:0] win_err;

    modport master (
        output src_bit, src_valid, dec_bit, dec_valid, clear,
        input  locked, delay_est, err_flag, err_cnt, bit_cnt, win_done, win_err
    );

    modport slave (
        input  src_bit, src_valid, dec_bit, dec_valid, clear,
        output locked, delay_est, err_flag, err_cnt, bit_cnt, win_done, win_err
    );
endinterface

// File: rtl/conv_ber_monitor.sv
// Bit-error monitor: finds the Viterbi decoder latency against a source-bit history, locks, then counts errors.
// Optional macro BER_LOSS_DETECT_EN drops lock when a completed window exceeds LOSS_THRESH errors.
module conv_ber_monitor #(
    parameter int MAX_DELAY   = 64,
    parameter int SEARCH_LEN  = 32,
    parameter int SEARCH_TOL  = 2,
    parameter int WIN_LEN     = 1024,
    parameter int LOSS_THRESH = 256,
    parameter int CNT_W       = 16
) (
    input  logic                 clk20M_sig,
    input  logic                 reset_sig,
    conv_ber_monitor_if.slave    bus
);
    localparam int DLY_W = $clog2(MAX_DELAY);
    localparam int IDX_W = $clog2(SEARCH_LEN + 1);
    localparam int WIN_W = $clog2(WIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef BER_LOSS_DETECT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    typedef enum logic {ST_SEARCH, ST_LOCK} state_t;

    state_t               r_state;
    logic [MAX_DELAY-1:0] r_hist;
    logic [MAX_DELAY-1:0] w_hist_d;
    logic [DLY_W-1:0]     r_delay_est;
    logic [IDX_W-1:0]     r_search_idx;
    logic [IDX_W-1:0]     r_search_err;
    logic [WIN_W-1:0]     r_win_cnt;
    logic [CNT_W-1:0]     r_win_acc;
    logic                 r_locked;
    logic                 r_err_flag;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_win_done;
    logic [CNT_W-1:0]     r_win_err;

    logic                 w_mis;
    logic [IDX_W-1:0]     w_idx_inc;
    logic [IDX_W-1:0]     w_serr_inc;
    logic [DLY_W-1:0]     w_delay_nxt;
    logic [CNT_W-1:0]     w_bit_inc;
    logic [CNT_W-1:0]     w_err_inc;
    logic [CNT_W-1:0]     w_acc_inc;
    logic                 w_search_end;
    logic                 w_search_ok;
    logic                 w_win_last;
    logic                 w_loss;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign w_hist_d[gi] = bus.src_bit;
            end else begin : g_tail
                assign w_hist_d[gi] = r_hist[gi-1];
            end
        end
    endgenerate

    // History is not touched by clear: the decoder pipeline still holds those bits.
    always_ff @(posedge clk20M_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_hist <= '0;
        end else if (bus.src_valid) begin
            r_hist <= w_hist_d;
        end
    end

    // Compare against the history as it stood before this cycle's shift.
    assign w_mis        = bus.dec_bit ^ r_hist[r_delay_est];
    assign w_idx_inc    = r_search_idx + IDX_W'(1);
    assign w_serr_inc   = r_search_err + IDX_W'(w_mis);
    assign w_search_end = (int'(w_idx_inc) == SEARCH_LEN);
    assign w_search_ok  = (int'(w_serr_inc) <= SEARCH_TOL);
    assign w_delay_nxt  = (int'(r_delay_est) == MAX_DELAY - 1) ? '0 : r_delay_est + DLY_W'(1);
    assign w_bit_inc    = (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
    assign w_err_inc    = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(w_mis);
    assign w_acc_inc    = (r_win_acc == CNT_MAX) ? r_win_acc : r_win_acc + CNT_W'(w_mis);
    assign w_win_last   = (int'(r_win_cnt) == WIN_LEN - 1);
    assign w_loss       = LOSS_EN && (int'(w_acc_inc) > LOSS_THRESH);

    always_ff @(posedge clk20M_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_state      <= ST_SEARCH;
            r_delay_est  <= '0;
            r_search_idx <= '0;
            r_search_err <= '0;
            r_win_cnt    <= '0;
            r_win_acc    <= '0;
            r_locked     <= 1'b0;
            r_err_flag   <= 1'b0;
            r_err_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_win_done   <= 1'b0;
            r_win_err    <= '0;
        end else if (bus.clear) begin
            r_state      <= ST_SEARCH;
            r_delay_est  <= '0;
            r_search_idx <= '0;
            r_search_err <= '0;
            r_win_cnt    <= '0;
            r_win_acc    <= '0;
            r_locked     <= 1'b0;
            r_err_flag   <= 1'b0;
            r_err_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_win_done   <= 1'b0;
            r_win_err    <= '0;
        end else begin
            r_err_flag <= 1'b0;
            r_win_done <= 1'b0;
            if (bus.dec_valid) begin
                if (r_state == ST_SEARCH) begin
                    if (w_search_end) begin
                        r_search_idx <= '0;
                        r_search_err <= '0;
                        if (w_search_ok) begin
                            r_state   <= ST_LOCK;
                            r_locked  <= 1'b1;
                            r_err_cnt <= '0;
                            r_bit_cnt <= '0;
                            r_win_cnt <= '0;
                            r_win_acc <= '0;
                        end else begin
                            r_delay_est <= w_delay_nxt;
                        end
                    end else begin
                        r_search_idx <= w_idx_inc;
                        r_search_err <= w_serr_inc;
                    end
                end else begin
                    r_err_flag <= w_mis;
                    r_bit_cnt  <= w_bit_inc;
                    r_err_cnt  <= w_err_inc;
                    if (w_win_last) begin
                        r_win_done <= 1'b1;
                        r_win_err  <= w_acc_inc;
                        r_win_cnt  <= '0;
                        r_win_acc  <= '0;
                        if (w_loss) begin
                            r_state     <= ST_SEARCH;
                            r_locked    <= 1'b0;
                            r_delay_est <= '0;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_win_acc <= w_acc_inc;
                    end
                end
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.delay_est = r_delay_est;
    assign bus.err_flag  = r_err_flag;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.bit_cnt   = r_bit_cnt;
    assign bus.win_done  = r_win_done;
    assign bus.win_err   = r_win_err;
endmodule

// File: tb/tb_conv_ber_monitor.sv
// Testbench for conv_ber_monitor: directed PRBS streams with a scoreboard for err_flag/win_done events.
// A second, narrow instance (CNT_W=4) exercises counter saturation.
module tb_conv_ber_monitor;
    localparam int WIN = 1024;

    logic clk20M_sig = 1'b0;
    logic reset_sig  = 1'b1;
    always #5 clk20M_sig = ~clk20M_sig;

    conv_ber_monitor_if #(.DLY_W(6), .CNT_W(16)) bus_a ();
    conv_ber_monitor_if #(.DLY_W(3), .CNT_W(4))  bus_b ();

    conv_ber_monitor dut_a (
        .clk20M_sig (clk20M_sig),
        .reset_sig  (reset_sig),
        .bus        (bus_a)
    );

    conv_ber_monitor #(
        .MAX_DELAY (8), .SEARCH_LEN (8), .SEARCH_TOL (2),
        .WIN_LEN (8), .LOSS_THRESH (256), .CNT_W (4)
    ) dut_b (
        .clk20M_sig (clk20M_sig),
        .reset_sig  (reset_sig),
        .bus        (bus_b)
    );

    int n_total = 0;
    int n_pass  = 0;

    int err_q[$];   // expected bit_cnt at each err_flag pulse
    int win_q[$];   // expected win_err at each win_done pulse

    logic [6:0] lfsr = 7'h5A;
    logic       src_mem[0:16383];
    int         n_src = 0;
    int         m_bits, m_pos, m_acc;
    logic       prev_b = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clk20M_sig) begin
        if (!reset_sig) begin
            if (bus_a.err_flag) begin
                if (err_q.size() == 0) check("err_flag_unexpected", 1, 0);
                else check("err_flag_bit_cnt", bus_a.bit_cnt, err_q.pop_front());
            end
            if (bus_a.win_done) begin
                if (win_q.size() == 0) check("win_done_unexpected", 1, 0);
                else check("win_err", bus_a.win_err, win_q.pop_front());
            end
        end
    end

    // Source shifts every step; dec is the source delayed by 7 valid bits, optionally flipped.
    task automatic step_a(input logic flip, input logic dv, input logic clr);
        logic s, d;
        s    = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], s};
        d    = (n_src >= 7) ? src_mem[n_src-7] : 1'b0;
        src_mem[n_src] = s;
        n_src++;
        bus_a.src_bit   = s;
        bus_a.src_valid = 1'b1;
        bus_a.dec_bit   = d ^ flip;
        bus_a.dec_valid = dv;
        bus_a.clear     = clr;
        @(posedge clk20M_sig);
        #1;
    endtask

    task automatic step_b(input logic flip);
        logic s;
        s = 1'($urandom_range(1));
        bus_b.src_bit   = s;
        bus_b.src_valid = 1'b1;
        bus_b.dec_bit   = prev_b ^ flip;
        bus_b.dec_valid = 1'b1;
        bus_b.clear     = 1'b0;
        prev_b = s;
        @(posedge clk20M_sig);
        #1;
    endtask

    task automatic model_reset();
        m_bits = 0;
        m_pos  = 0;
        m_acc  = 0;
    endtask

    task automatic run_locked(input int n, input int f0, input int f1, input int f2, input int inv_n);
        logic fl;
        for (int i = 0; i < n; i++) begin
            fl = (i == f0) || (i == f1) || (i == f2) || (i < inv_n);
            m_bits++;
            if (fl) begin
                err_q.push_back(m_bits);
                m_acc++;
            end
            m_pos++;
            if (m_pos == WIN) begin
                win_q.push_back(m_acc);
                m_pos = 0;
                m_acc = 0;
            end
            step_a(fl, 1'b1, 1'b0);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_locked"},    bus_a.locked,    0);
        check({tag, "_delay_est"}, bus_a.delay_est, 0);
        check({tag, "_err_flag"},  bus_a.err_flag,  0);
        check({tag, "_err_cnt"},   bus_a.err_cnt,   0);
        check({tag, "_bit_cnt"},   bus_a.bit_cnt,   0);
        check({tag, "_win_done"},  bus_a.win_done,  0);
        check({tag, "_win_err"},   bus_a.win_err,   0);
    endtask

    initial begin
        bus_a.src_bit = 0; bus_a.src_valid = 0; bus_a.dec_bit = 0; bus_a.dec_valid = 0; bus_a.clear = 0;
        bus_b.src_bit = 0; bus_b.src_valid = 0; bus_b.dec_bit = 0; bus_b.dec_valid = 0; bus_b.clear = 0;
        model_reset();
        repeat (2) @(posedge clk20M_sig);
        #1;
        check_a_zero("reset");
        reset_sig = 1'b0;

        // Basic lock: true delay index 6, found after 7 passes of 32 bits.
        for (int i = 1; i <= 224; i++) begin
            step_a(1'b0, 1'b1, 1'b0);
            if (i == 192) check("search_cand6", bus_a.delay_est, 6);
            if (i == 223) check("search_not_yet_locked", bus_a.locked, 0);
        end
        check("lock_locked", bus_a.locked, 1);
        check("lock_delay_est", bus_a.delay_est, 6);
        check("lock_err_cnt", bus_a.err_cnt, 0);
        check("lock_bit_cnt", bus_a.bit_cnt, 0);

        // One clean window, then one with errors at 10, 500 and 1023.
        model_reset();
        run_locked(WIN, -1, -1, -1, 0);
        run_locked(WIN, 10, 500, 1023, 0);
        check("win2_err_cnt", bus_a.err_cnt, 3);
        check("win2_bit_cnt", bus_a.bit_cnt, 2048);
        check("win2_win_err", bus_a.win_err, 3);
        run_locked(50, -1, -1, -1, 0);
        check("win_err_held", bus_a.win_err, 3);

        // Clear mid-lock, with a mismatching dec_valid on the same cycle.
        step_a(1'b1, 1'b1, 1'b1);
        check("clear_locked", bus_a.locked, 0);
        check("clear_delay_est", bus_a.delay_est, 0);
        check("clear_err_cnt", bus_a.err_cnt, 0);
        check("clear_bit_cnt", bus_a.bit_cnt, 0);
        check("clear_win_err", bus_a.win_err, 0);

        // Tolerance: 2 flips in the delay-6 pass still lock.
        for (int i = 0; i < 224; i++) step_a(1'(i >= 192 && i < 194), 1'b1, 1'b0);
        check("tol2_locked", bus_a.locked, 1);
        check("tol2_delay_est", bus_a.delay_est, 6);
        step_a(1'b0, 1'b1, 1'b1);

        // Tolerance: 3 flips reject delay 6; search wraps 63->0 and locks on the next pass.
        for (int i = 0; i < 2272; i++) begin
            step_a(1'(i >= 192 && i < 195), 1'b1, 1'b0);
            if (i == 223) begin
                check("tol3_not_locked", bus_a.locked, 0);
                check("tol3_cand7", bus_a.delay_est, 7);
            end
            if (i == 2046) check("tol3_cand63", bus_a.delay_est, 63);
            if (i == 2047) check("tol3_wrap0", bus_a.delay_est, 0);
        end
        check("tol3_locked", bus_a.locked, 1);
        check("tol3_delay_est", bus_a.delay_est, 6);

        // Heavy-error window: first 300 bits inverted.
        model_reset();
        run_locked(WIN, -1, -1, -1, 300);
        check("loss_win_err", bus_a.win_err, 300);
        check("loss_err_cnt", bus_a.err_cnt, 300);
        check("loss_bit_cnt", bus_a.bit_cnt, 1024);
`ifdef BER_LOSS_DETECT_EN
        check("loss_locked", bus_a.locked, 0);
        check("loss_delay_est", bus_a.delay_est, 0);
`else
        check("loss_locked", bus_a.locked, 1);
        check("loss_delay_est", bus_a.delay_est, 6);
`endif
        bus_a.dec_valid = 1'b0;

        // Saturation on the 4-bit instance.
        for (int i = 0; i < 8; i++) step_b(1'b0);
        check("b_locked", bus_b.locked, 1);
        check("b_delay_est", bus_b.delay_est, 0);
        for (int i = 1; i <= 20; i++) begin
            step_b(1'b1);
            if (i == 14) begin
                check("b_err_cnt14", bus_b.err_cnt, 14);
                check("b_bit_cnt14", bus_b.bit_cnt, 14);
            end
            if (i == 15) check("b_err_cnt15", bus_b.err_cnt, 15);
        end
        check("b_err_cnt_sat", bus_b.err_cnt, 15);
        check("b_bit_cnt_sat", bus_b.bit_cnt, 15);
        check("b_win_err", bus_b.win_err, 8);
        check("b_still_locked", bus_b.locked, 1);
        bus_b.dec_valid = 1'b0;

        // Asynchronous reset between edges.
        #3;
        reset_sig = 1'b1;
        #1;
        check_a_zero("async_reset");
        check("async_reset_b_err_cnt", bus_b.err_cnt, 0);
        @(posedge clk20M_sig);
        #1;
        reset_sig = 1'b0;

        repeat (3) @(posedge clk20M_sig);
        #1;
        check("err_q_drained", err_q.size(), 0);
        check("win_q_drained", win_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
